seq_det_ctrl: RTL and testbench

Programmable serial pattern-detector controller. It accepts a pattern, length and overlap mode through a config handshake, then runs detection on a gated serial bit stream. It counts matches and ends the run after a programmable hit count or on abort. It generalises the team's fixed-pattern Mealy detectors into one configurable block sequenced by a host.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_det_window.sv | 47 ++++
 rtl/seq_det_ctrl.sv | 106 ++++++++++
 tb/tb_seq_det_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int MAXLEN_D = 8;
  localparam int CW_D     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/seq_det_window.sv
// Serial shift window with fill tracking and a length-masked pattern compare.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_D,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic              in,
  input  logic              overlap,
  input  logic [LW-1:0]     len,
  input  logic [MAXLEN-1:0] pattern,
  output logic              hit
);

  logic [MAXLEN-1:0] win;
  logic [MAXLEN-1:0] win_nx;
  logic [MAXLEN-1:0] mask;
  logic [LW-1:0]     fill;
  logic [LW-1:0]     fill_nx;

  always_comb begin
    win_nx  = (win << 1) | MAXLEN'(in);
    fill_nx = (fill == LW'(MAXLEN)) ? fill : fill + 1'b1;
    mask    = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (i < int'(len));
    end
    // len of zero would give an empty mask that trivially compares equal
    hit = shift && (len != '0) && (fill_nx >= len) &&
          (((win_nx ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win  <= '0;
      fill <= '0;
    end else if (shift) begin
      win  <= win_nx;
      fill <= (hit && !overlap) ? '0 : fill_nx;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Host-sequenced controller: config handshake, run control, hit counting
// and auto-stop around the serial match window.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_D,
  parameter int CW     = CW_D,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic [CW-1:0]     cfg_max_hits,
  input  logic              start,
  input  logic              abort,
  input  logic              in,
  input  logic              in_valid,
  output logic              match,
  output logic [CW-1:0]     hit_count,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [MAXLEN-1:0] pat_q;
  logic [LW-1:0]     len_q;
  logic              ovl_q;
  logic [CW-1:0]     max_q;
  logic              hit;
  logic              shift;
  logic              go;
  logic              cfg_hs;
  logic              last;
  logic [CW-1:0]     cnt_nx;

  assign busy      = (state == RUN);
  assign cfg_ready = !busy;
  assign cfg_hs    = cfg_valid & cfg_ready;
  assign go        = (state == LOADED) && start;
  assign shift     = busy & in_valid;
  assign cnt_nx    = (hit && hit_count != '1) ? hit_count + 1'b1 : hit_count;
  assign last      = hit && (max_q != '0) && (cnt_nx == max_q);

  seq_det_window #(
    .MAXLEN (MAXLEN),
    .LW     (LW)
  ) u_win (
    .clk     (clk),
    .rst     (rst),
    .clr     (go),
    .shift   (shift),
    .in      (in),
    .overlap (ovl_q),
    .len     (len_q),
    .pattern (pat_q),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      max_q     <= '0;
      hit_count <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      if (cfg_hs) begin
        pat_q <= cfg_pattern;
        len_q <= (cfg_len > LW'(MAXLEN)) ? LW'(MAXLEN) : cfg_len;
        ovl_q <= cfg_overlap;
        max_q <= cfg_max_hits;
      end
      unique case (state)
        IDLE: begin
          if (cfg_hs) state <= LOADED;
        end
        LOADED: begin
          if (start) begin
            state     <= RUN;
            hit_count <= '0;
          end
        end
        RUN: begin
          match     <= hit;
          hit_count <= cnt_nx;
          // a hit coinciding with abort still counts; done fires once
          if (last || abort) begin
            done  <= 1'b1;
            state <= LOADED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench: a bit-history reference model predicts each cycle's
// outputs, queues them, and compares after the clock edge.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_max_hits;
  logic       start;
  logic       abort;
  logic       in;
  logic       in_valid;
  logic       match;
  logic [7:0] hit_count;
  logic       busy;
  logic       done;

  typedef struct {
    logic       match;
    logic       done;
    logic       busy;
    logic       ready;
    logic [7:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  string       phase   = "reset";

  int          m_state;
  int          m_cnt;
  int          m_len;
  logic [7:0]  m_pat;
  logic        m_ovl;
  int          m_max;
  logic [31:0] hb;
  int          hn;

  always #5 clk = ~clk;

  seq_det_ctrl #(
    .MAXLEN (8),
    .CW     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_overlap  (cfg_overlap),
    .cfg_max_hits (cfg_max_hits),
    .start        (start),
    .abort        (abort),
    .in           (in),
    .in_valid     (in_valid),
    .match        (match),
    .hit_count    (hit_count),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s.%s got %0d exp %0d", phase, tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t        e;
    exp_t        g;
    bit          st;
    logic [31:0] mask;
    e.match = 1'b0;
    e.done  = 1'b0;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_len = 0; m_pat = '0;
      m_ovl = 1'b0; m_max = 0; hb = '0; hn = 0;
    end else if (m_state == 2) begin
      if (in_valid) begin
        hb   = {hb[30:0], in};
        hn++;
        mask = (32'd1 << m_len) - 32'd1;
        if (m_len != 0 && hn >= m_len &&
            (hb & mask) == ({24'd0, m_pat} & mask)) begin
          e.match = 1'b1;
          if (m_cnt != 255) m_cnt++;
          if (!m_ovl) hn = 0;
          if (m_max != 0 && m_cnt == m_max) begin
            e.done  = 1'b1;
            m_state = 1;
          end
        end
      end
      if (abort) begin
        e.done  = 1'b1;
        m_state = 1;
      end
    end else begin
      st = (m_state == 1) && start;
      if (cfg_valid) begin
        m_pat   = cfg_pattern;
        m_len   = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
        m_ovl   = cfg_overlap;
        m_max   = int'(cfg_max_hits);
        m_state = 1;
      end
      if (st) begin
        m_state = 2; m_cnt = 0; hb = '0; hn = 0;
      end
    end
    e.cnt   = 8'(m_cnt);
    e.busy  = (m_state == 2);
    e.ready = (m_state != 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("match", int'(match), int'(g.match));
    chk("done", int'(done), int'(g.done));
    chk("busy", int'(busy), int'(g.busy));
    chk("ready", int'(cfg_ready), int'(g.ready));
    chk("count", int'(hit_count), int'(g.cnt));
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic [7:0] mx);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l;
    cfg_overlap = o;  cfg_max_hits = mx;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      in = bits[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < gap; k++) begin
        in = 1'($urandom_range(0, 1));
        tick();
      end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_max_hits = '0; start = 1'b0; abort = 1'b0;
    in = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();

    phase = "rst_mid_run";
    do_cfg(8'b11011, 4'd5, 1'b1, 8'd0);
    do_start();
    send(32'b110, 3, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    do_start();
    tick();

    phase = "overlap";
    do_cfg(8'b11011, 4'd5, 1'b1, 8'd0);
    do_start();
    send(32'b11011011, 8, 0);
    tick();

    phase = "no_overlap";
    abort = 1'b1; tick(); abort = 1'b0;
    do_cfg(8'b11011, 4'd5, 1'b0, 8'd0);
    do_start();
    send(32'b11011011, 8, 0);
    abort = 1'b1; tick(); abort = 1'b0;

    phase = "max_hits";
    do_cfg(8'b11, 4'd2, 1'b1, 8'd2);
    do_start();
    send(32'b111, 3, 0);
    send(32'b11, 2, 0);
    tick();

    phase = "gaps";
    do_cfg(8'b11011, 4'd5, 1'b1, 8'd0);
    do_start();
    send(32'b11011011, 8, 2);
    abort = 1'b1; tick(); abort = 1'b0;

    phase = "abort_hit";
    do_start();
    send(32'b1101, 4, 0);
    in = 1'b1; in_valid = 1'b1; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    tick();
    tick();
    do_start();
    tick();
    abort = 1'b1; tick(); abort = 1'b0;

    phase = "len_zero";
    do_cfg(8'hFF, 4'd0, 1'b1, 8'd0);
    do_start();
    send(32'b1111, 4, 0);
    abort = 1'b1; tick(); abort = 1'b0;

    phase = "len_clamp";
    do_cfg(8'hA5, 4'd15, 1'b1, 8'd0);
    do_start();
    send(32'h3A5A5, 18, 0);
    abort = 1'b1; tick(); abort = 1'b0;

    phase = "start_abort";
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    tick();

    phase = "saturate";
    abort = 1'b1; tick(); abort = 1'b0;
    do_cfg(8'b1, 4'd1, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 9; i++) send(32'hFFFFFFFF, 32, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
